// File: rtl/systolic_pkg.sv
// Shared FSM state type and coordinate-width helper for the systolic-array drain logic.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_VALID,
    RELEASE,
    FINISH
  } drain_state_e;

  // Never returns zero, so a 1x1 grid still gets a usable 1-bit coordinate.
  function automatic int coord_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accumulator_drain_if.sv
// Result stream leaving the drain block: valid/ready with data, PE coordinates and last flag.
interface accumulator_drain_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);
  import systolic_pkg::*;

  localparam int CW = coord_width(N);

  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [CW-1:0]         m_row_o;
  logic [CW-1:0]         m_col_o;
  logic                  m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_row_o,
    output m_col_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_row_o,
    input  m_col_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering drained entries; the head word reads as zero while empty.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/accumulator_drain.sv
// Walks the N x N PE grid in raster order, selects one accumulator at a time and
// streams its value with (row,col) coordinates through a small output FIFO.
module accumulator_drain
  import systolic_pkg::*;
#(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic [N*N-1:0]          select_o,
  input  logic [N*N-1:0]          acc_valid_i,
  input  logic [N*DATA_WIDTH-1:0] row_data_i,
  accumulator_drain_if.master     m,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_err_o
);

  localparam int CW = coord_width(N);
  localparam int IW = coord_width(N * N);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = DATA_WIDTH + 2 * CW + 1;
  localparam logic [CW-1:0] LAST_COORD = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  drain_state_e          state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [N*N-1:0]        sel_q, sel_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  is_last;
  logic                  tmo_hit;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_word;
  logic [EW-1:0]         push_entry;
  logic                  pop;
  logic [EW-1:0]         pop_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  stream_valid;

  logic [DATA_WIDTH-1:0] row_words [N];

  for (genvar g = 0; g < N; g++) begin : g_rows
    assign row_words[g] = row_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign is_last = (row_q == LAST_COORD) && (col_q == LAST_COORD);
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Next-state logic; a valid in the same cycle as the timeout still wins.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    done_d     = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    push_entry = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = SELECT;
        end
      end

      SELECT: begin
        if (!fifo_full) begin
          sel_d        = '0;
          sel_d[idx_q] = 1'b1;
          tmo_d        = '0;
          state_d      = WAIT_VALID;
        end
      end

      WAIT_VALID: begin
        if (acc_valid_i[idx_q] || tmo_hit) begin
          if (acc_valid_i[idx_q]) begin
            push_word = row_words[row_q];
          end else begin
            err_d = 1'b1;
          end
          push       = 1'b1;
          push_entry = {is_last, row_q, col_q, push_word};
          sel_d      = '0;
          state_d    = RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RELEASE: begin
        if (is_last) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == LAST_COORD) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          state_d = SELECT;
        end
      end

      FINISH: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // SELECT only proceeds with a free slot, so a push never meets a full FIFO.
  result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign stream_valid = !fifo_empty;
  assign pop          = stream_valid && m.m_ready_i;

  assign m.m_valid_o = stream_valid;
  assign {m.m_last_o, m.m_row_o, m.m_col_o, m.m_data_o} = pop_entry;

  assign select_o      = sel_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_accumulator_drain.sv
// Randomised bench for accumulator_drain: PE grid model, raster-order reference queue, stream scoreboard.
module tb_accumulator_drain;
  import systolic_pkg::*;

  localparam int N     = 2;
  localparam int DW    = 16;
  localparam int TMO   = 8;
  localparam int DEPTH = 2;
  localparam int NN    = N * N;
  localparam int CW    = coord_width(N);

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            col;
    bit            last;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [NN-1:0]   select_o;
  logic [NN-1:0]   acc_valid_i = '0;
  logic [N*DW-1:0] row_data_i = '0;
  logic            busy_o;
  logic            done_o;
  logic            timeout_err_o;

  accumulator_drain_if #(.N(N), .DATA_WIDTH(DW)) m_if ();

  accumulator_drain #(
    .N              (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .select_o      (select_o),
    .acc_valid_i   (acc_valid_i),
    .row_data_i    (row_data_i),
    .m             (m_if),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [DW-1:0] pe_val [NN] = '{default: '0};
  bit            dead   [NN] = '{default: 1'b0};
  int            lat    [NN] = '{default: 1};
  int            cnt    [NN] = '{default: 0};

  entry_t exp_q[$];
  bit     exp_err;
  bit     rand_ready = 1'b0;
  int     ready_low  = 0;
  int     cyc        = 0;
  int     done_cnt, pop_cnt, sel_events, onehot_viol, gap_viol, hold_viol;
  int     sel_times[$];
  logic [NN-1:0]      prev_sel = '0;
  bit                 prev_stall = 1'b0;
  logic [DW+2*CW:0]   held = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  always @(posedge clk) cyc++;

  // PE grid model, sink ready, and stream scoreboard, all evaluated mid-cycle.
  always @(negedge clk) begin
    entry_t e;
    for (int k = 0; k < NN; k++) begin
      if (select_o[k]) cnt[k]++;
      else cnt[k] = 0;
      acc_valid_i[k] = select_o[k] ? (!dead[k] && cnt[k] > lat[k]) : 1'($urandom_range(0, 1));
    end
    for (int r = 0; r < N; r++) row_data_i[r*DW +: DW] = DW'($urandom);
    for (int k = 0; k < NN; k++) if (select_o[k]) row_data_i[(k/N)*DW +: DW] = pe_val[k];

    if (ready_low > 0) begin
      m_if.m_ready_i = 1'b0;
      ready_low--;
    end else if (rand_ready) m_if.m_ready_i = 1'($urandom_range(0, 1));
    else m_if.m_ready_i = 1'b1;

    if (!$onehot0(select_o)) onehot_viol++;
    if (select_o != '0 && prev_sel != '0 && select_o != prev_sel) gap_viol++;
    if (select_o != '0 && select_o != prev_sel) begin
      sel_events++;
      sel_times.push_back(cyc);
    end
    prev_sel = select_o;
    if (done_o) done_cnt++;

    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall &&
          (!m_if.m_valid_o || {m_if.m_last_o, m_if.m_row_o, m_if.m_col_o, m_if.m_data_o} != held))
        hold_viol++;
      if (m_if.m_valid_o && m_if.m_ready_i) begin
        pop_cnt++;
        checkOutput("pop_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("data", 64'(m_if.m_data_o), 64'(e.data));
          checkOutput("row", 64'(m_if.m_row_o), 64'(e.row));
          checkOutput("col", 64'(m_if.m_col_o), 64'(e.col));
          checkOutput("last", 64'(m_if.m_last_o), 64'(e.last));
        end
      end
      prev_stall = m_if.m_valid_o && !m_if.m_ready_i;
      held = {m_if.m_last_o, m_if.m_row_o, m_if.m_col_o, m_if.m_data_o};
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1 rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic randomPes(input bit fixed_lat, input bit allow_dead);
    for (int k = 0; k < NN; k++) begin
      pe_val[k] = DW'($urandom);
      lat[k]    = fixed_lat ? 1 : int'($urandom_range(1, 3));
      dead[k]   = allow_dead && ($urandom_range(0, 5) == 0);
    end
  endtask

  // Reference: one entry per PE in raster order; a silent PE contributes zero and raises the error flag.
  task automatic buildExpected();
    entry_t e;
    exp_q.delete();
    exp_err = 1'b0;
    for (int k = 0; k < NN; k++) begin
      e.data = dead[k] ? '0 : pe_val[k];
      e.row  = k / N;
      e.col  = k % N;
      e.last = (k == NN - 1);
      if (dead[k]) exp_err = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic clearCounters();
    done_cnt = 0; pop_cnt = 0; sel_events = 0;
    onehot_viol = 0; gap_viol = 0; hold_viol = 0;
    sel_times.delete();
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 64'(done_cnt > 0), 1);
  endtask

  task automatic runDrain(input bit chk_spacing, input int stall_cycles, input int repulse);
    buildExpected();
    clearCounters();
    ready_low = stall_cycles;
    applyStimulus();
    @(negedge clk);
    checkOutput("busy_running", 64'(busy_o), 1);
    if (stall_cycles > 0) begin
      repeat (14) @(negedge clk);
      checkOutput("stall_selects", 64'(sel_events), 2);
      checkOutput("stall_select_idle", 64'(select_o), 0);
      checkOutput("stall_valid", 64'(m_if.m_valid_o), 1);
      checkOutput("stall_head", 64'(m_if.m_data_o), 64'(exp_q[0].data));
    end
    for (int i = 0; i < repulse; i++) begin
      repeat (2) @(posedge clk);
      applyStimulus();
    end
    waitDone(2000);
    repeat (4) @(negedge clk);
    checkOutput("done_once", 64'(done_cnt), 1);
    checkOutput("entry_count", 64'(pop_cnt), NN);
    checkOutput("expected_drained", 64'(exp_q.size()), 0);
    checkOutput("timeout_err", 64'(timeout_err_o), 64'(exp_err));
    checkOutput("busy_after", 64'(busy_o), 0);
    checkOutput("onehot_select", 64'(onehot_viol), 0);
    checkOutput("release_gap", 64'(gap_viol), 0);
    checkOutput("hold_stable", 64'(hold_viol), 0);
    if (chk_spacing) begin
      checkOutput("select_events", 64'(sel_times.size()), NN);
      if (sel_times.size() == NN)
        checkOutput("pe_spacing", 64'(sel_times[NN-1] - sel_times[0]), 64'((NN - 1) * 4));
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_select", 64'(select_o), 0);
    checkOutput("rst_valid", 64'(m_if.m_valid_o), 0);
    checkOutput("rst_data", 64'(m_if.m_data_o), 0);
    checkOutput("rst_row", 64'(m_if.m_row_o), 0);
    checkOutput("rst_col", 64'(m_if.m_col_o), 0);
    checkOutput("rst_last", 64'(m_if.m_last_o), 0);
    checkOutput("rst_busy", 64'(busy_o), 0);
    checkOutput("rst_done", 64'(done_o), 0);
    checkOutput("rst_err", 64'(timeout_err_o), 0);

    $display("[TB] basic drain 1,2,3,4");
    for (int k = 0; k < NN; k++) begin
      pe_val[k] = DW'(k + 1);
      lat[k]    = 1;
      dead[k]   = 1'b0;
    end
    runDrain(1'b1, 0, 0);

    $display("[TB] sink stalled after start");
    randomPes(1'b1, 1'b0);
    runDrain(1'b0, 20, 0);

    $display("[TB] PE(0,1) silent");
    applyReset();
    randomPes(1'b1, 1'b0);
    dead[1] = 1'b1;
    runDrain(1'b0, 0, 0);

    $display("[TB] reset while waiting on PE(1,0)");
    applyReset();
    randomPes(1'b1, 1'b0);
    dead[1*N+0] = 1'b1;
    buildExpected();
    clearCounters();
    applyStimulus();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (select_o[1*N+0]) found = 1'b1;
    end
    checkOutput("reach_pe10", 64'(found), 1);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_select", 64'(select_o), 0);
    checkOutput("midrst_valid", 64'(m_if.m_valid_o), 0);
    checkOutput("midrst_busy", 64'(busy_o), 0);
    checkOutput("midrst_err", 64'(timeout_err_o), 0);
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_done", 64'(done_cnt), 0);
    dead[1*N+0] = 1'b0;
    runDrain(1'b0, 0, 0);

    $display("[TB] start re-pulsed mid-drain");
    randomPes(1'b1, 1'b0);
    runDrain(1'b0, 0, 3);

    $display("[TB] randomised drains");
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      applyReset();
      randomPes(1'b0, 1'b1);
      runDrain(1'b0, 0, 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/accumulator_drain.md
ACCUMULATOR_DRAIN -- requirements
Module: accumulator_drain

Interface
REQ-001 SHALL have parameter N, default 8, giving the PE grid dimension (N x N).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the accumulator word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum wait for an accumulator valid.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2 (power of 2, >=2), giving the output buffer depth.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start_i, input, 1 bit: pulse that begins a drain; driven by the array's matrix_mult_complete_o.
REQ-008 SHALL have port select_o, output, N*N bits: one-hot PE select; bit r*N+c drives select_accumulator[r][c].
REQ-009 SHALL have port acc_valid_i, input, N*N bits: accumulator_valid_o of PE (r,c) on bit r*N+c.
REQ-010 SHALL have port row_data_i, input, N*DATA_WIDTH bits: the row-r data path at the selected PE output on slice r.
REQ-011 SHALL have port m_valid_o, input m_ready_i, and output m_data_o (DATA_WIDTH bits): the result stream.
REQ-012 SHALL have ports m_row_o and m_col_o, outputs, $clog2(N) bits each, plus m_last_o, output, 1 bit: coordinates of m_data_o, and last-element flag.
REQ-013 SHALL have outputs busy_o, done_o and timeout_err_o, 1 bit each.

Function
REQ-014 SHALL implement FSM states IDLE, SELECT, WAIT_VALID, RELEASE and FINISH.
REQ-015 In IDLE, start_i SHALL clear the index to (0,0) and enter SELECT; start_i outside IDLE SHALL be ignored.
REQ-016 In SELECT, if the FIFO is not full, the FSM SHALL assert select_o bit idx on the next cycle and enter WAIT_VALID; otherwise it SHALL stall in SELECT.
REQ-017 In WAIT_VALID, on the first cycle acc_valid_i[idx]=1, the block SHALL push row_data_i[row] with (row,col) into the FIFO and enter RELEASE.
REQ-018 In RELEASE, select_o SHALL be all-zero for exactly one cycle; the FSM SHALL then advance the raster index (col first, wrap col N-1->0 and increment row) and return to SELECT, or go to FINISH after (N-1,N-1).
REQ-019 If TIMEOUT_CYCLES cycles elapse in WAIT_VALID without valid, the block SHALL push data 0, set timeout_err_o (sticky until reset), and continue to RELEASE.
REQ-020 select_o SHALL have at most one bit set at any time.
REQ-021 Minimum spacing SHALL be 4 cycles per PE with an always-ready sink and a valid that arrives in 1 cycle.
REQ-022 The stream SHALL follow valid/ready: m_valid_o=FIFO not empty; the head SHALL pop when m_valid_o and m_ready_i are both 1; outputs SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-023 A push and a pop in the same cycle on a full FIFO SHALL NOT be allowed; the FSM gating in REQ-016 SHALL guarantee this.
REQ-024 m_last_o SHALL be 1 only with the (N-1,N-1) entry.
REQ-025 FINISH SHALL wait for the FIFO to empty, pulse done_o for one cycle, and return to IDLE.
REQ-026 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-027 While rst_i=1 at a clock edge, the block SHALL force IDLE, select_o=0, FIFO empty, m_valid_o=0, m_data_o=0, m_row_o=0, m_col_o=0, m_last_o=0, busy_o=0, done_o=0, timeout_err_o=0, and clear the timeout counter.
REQ-028 A reset mid-drain SHALL discard pending entries and SHALL produce no done_o.

Structure
REQ-029 The FSM state enum and the index/coordinate width function SHALL be placed in shared package systolic_pkg.
REQ-030 The output buffer SHALL be the single sub-module result_fifo (synchronous, DATA_WIDTH+2*$clog2(N)+1 bits wide, FIFO_DEPTH deep).

Verification
REQ-031 N=2 with PE values 1,2,3,4, valid 1 cycle after select, and ready held 1: the stream SHALL be (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4 with last on the fourth, then a done_o pulse.
REQ-032 m_ready_i=0 for 20 cycles after start: stalling SHALL begin after 2 entries, held outputs SHALL be unchanged, and no entries SHALL be lost or duplicated after ready rises.
REQ-033 PE(0,1) never raises valid and TIMEOUT_CYCLES=8: the entry SHALL be 0 at (0,1), timeout_err_o SHALL be 1, and the remaining entries SHALL be correct.
REQ-034 rst_i=1 while in WAIT_VALID on PE(1,0): the next edge SHALL give select_o=0 and m_valid_o=0, there SHALL be no done_o, and a later start_i SHALL give a full correct drain.
REQ-035 start_i re-pulsed mid-drain: it SHALL be ignored, with exactly N*N entries and one done_o.
REQ-036 Every cycle SHALL satisfy $onehot0(select_o), and RELEASE SHALL give a zero gap between consecutive selects.
